ftdi_fifo_arbiter: RTL and testbench

//  Owns the shared 8-bit FT232H-style 245 FIFO bus (ADBUS + ACBUS rxf/txe, rd/wr strobes).

---
 rtl/laser_pkg.sv | 25 ++
 rtl/ftdi_fifo_arbiter_if.sv | 29 ++
 rtl/bit_sync.sv | 24 ++
 rtl/ftdi_fifo_arbiter.sv | 161 ++++++++++++++++
 tb/tb_ftdi_fifo_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/laser_pkg.sv
// Shared types and protocol constants for the laser link FTDI front end.
package laser_pkg;

  // Arbiter FSM states; IDLE must stay at encoding 0.
  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    RD_STROBE  = 3'd1,
    RD_RECOVER = 3'd2,
    WR_SETUP   = 3'd3,
    WR_STROBE  = 3'd4,
    WR_HOLD    = 3'd5,
    TURN       = 3'd6
  } ftdi_arb_state_t;

  // Packet header bytes exchanged with the host.
  localparam logic [7:0] START_SEQ = 8'h53;
  localparam logic [7:0] STOP_SEQ  = 8'h50;
  localparam logic [7:0] ACK_SEQ   = 8'h41;
  localparam logic [7:0] DONE_SEQ  = 8'h44;

  // Packet lengths in bytes, header included.
  localparam int unsigned START_PKT_LEN = 6;
  localparam int unsigned STOP_PKT_LEN  = 2;

endpackage

// File: rtl/ftdi_fifo_arbiter_if.sv
// FT245-style FIFO pins plus the read/write requester handshakes.
interface ftdi_fifo_arbiter_if;
  logic       ftdi_rxf_n;
  logic       ftdi_txe_n;
  logic       ftdi_rd;
  logic       ftdi_wr;
  logic [7:0] ad_in;
  logic [7:0] ad_out;
  logic       ad_oe;
  logic       rd_req;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       wr_valid;
  logic [7:0] wr_data;
  logic       wr_ready;
  logic       busy;

  // Arbiter side: owns the strobes and the bus drive.
  modport master (
    input  ftdi_rxf_n, ftdi_txe_n, ad_in, rd_req, wr_valid, wr_data,
    output ftdi_rd, ftdi_wr, ad_out, ad_oe, rd_data, rd_valid, wr_ready, busy
  );

  // Pins and requesters as seen from outside the arbiter.
  modport slave (
    output ftdi_rxf_n, ftdi_txe_n, ad_in, rd_req, wr_valid, wr_data,
    input  ftdi_rd, ftdi_wr, ad_out, ad_oe, rd_data, rd_valid, wr_ready, busy
  );
endinterface

// File: rtl/bit_sync.sv
// Two-flop synchronizer for a single asynchronous level.
module bit_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Metastability stage followed by the output stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/ftdi_fifo_arbiter.sv
// Owns the shared 245 FIFO bus and alternates between host reads and host writes.
module ftdi_fifo_arbiter
  import laser_pkg::*;
#(
  parameter int unsigned RD_PULSE_CYC = 3,
  parameter int unsigned WR_PULSE_CYC = 2,
  parameter int unsigned TURN_CYC     = 1
) (
  input  logic                 clock,
  input  logic                 resetN,
  ftdi_fifo_arbiter_if.master  bus
);

  localparam int unsigned RW_MAX  = (RD_PULSE_CYC > WR_PULSE_CYC) ? RD_PULSE_CYC : WR_PULSE_CYC;
  localparam int unsigned CNT_MAX = (RW_MAX > TURN_CYC) ? RW_MAX : TURN_CYC;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  ftdi_arb_state_t  state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_wr_q, last_wr_d;
  logic             rd_n_q, rd_n_d;
  logic             wr_n_q, wr_n_d;
  logic             ad_oe_q, ad_oe_d;
  logic [7:0]       ad_out_q, ad_out_d;
  logic [7:0]       rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;
  logic             busy_q;
  logic             wr_ready_c;

  logic rxf_s, txe_s;
  logic rd_el, wr_el, grant_rd, grant_wr;

  bit_sync #(.RST_VAL(1'b1)) u_rxf_sync (
    .clk   (clock),
    .rst_n (resetN),
    .d     (bus.ftdi_rxf_n),
    .q     (rxf_s)
  );

  bit_sync #(.RST_VAL(1'b1)) u_txe_sync (
    .clk   (clock),
    .rst_n (resetN),
    .d     (bus.ftdi_txe_n),
    .q     (txe_s)
  );

  // Eligibility and alternating grant; only consumed while in IDLE.
  always_comb begin
    rd_el    = bus.rd_req & ~rxf_s;
    wr_el    = bus.wr_valid & ~txe_s;
    grant_rd = rd_el & (~wr_el | last_wr_q);
    grant_wr = wr_el & ~grant_rd;
  end

  // Next state, counter and next values of every registered output.
  always_comb begin
    state_d    = state_q;
    cnt_d      = (cnt_q != '0) ? cnt_q - CNT_W'(1) : '0;
    last_wr_d  = last_wr_q;
    rd_n_d     = 1'b1;
    wr_n_d     = 1'b1;
    ad_oe_d    = 1'b0;
    ad_out_d   = ad_out_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    wr_ready_c = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (grant_rd) begin
          state_d   = RD_STROBE;
          cnt_d     = CNT_W'(RD_PULSE_CYC - 1);
          rd_n_d    = 1'b0;
          last_wr_d = 1'b0;
        end else if (grant_wr) begin
          state_d    = WR_SETUP;
          wr_ready_c = 1'b1;
          ad_out_d   = bus.wr_data;
          ad_oe_d    = 1'b1;
          last_wr_d  = 1'b1;
        end
      end
      RD_STROBE: begin
        if (cnt_q == '0) begin
          state_d    = RD_RECOVER;
          rd_data_d  = bus.ad_in;
          rd_valid_d = 1'b1;
        end else begin
          rd_n_d = 1'b0;
        end
      end
      RD_RECOVER: begin
        state_d = IDLE;
      end
      WR_SETUP: begin
        state_d = WR_STROBE;
        cnt_d   = CNT_W'(WR_PULSE_CYC - 1);
        wr_n_d  = 1'b0;
        ad_oe_d = 1'b1;
      end
      WR_STROBE: begin
        ad_oe_d = 1'b1;
        if (cnt_q == '0) begin
          state_d = WR_HOLD;
        end else begin
          wr_n_d = 1'b0;
        end
      end
      WR_HOLD: begin
        state_d = TURN;
        cnt_d   = CNT_W'(TURN_CYC - 1);
      end
      TURN: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, counter and output registers; reset leaves the bus released.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      last_wr_q  <= 1'b1;
      rd_n_q     <= 1'b1;
      wr_n_q     <= 1'b1;
      ad_oe_q    <= 1'b0;
      ad_out_q   <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_wr_q  <= last_wr_d;
      rd_n_q     <= rd_n_d;
      wr_n_q     <= wr_n_d;
      ad_oe_q    <= ad_oe_d;
      ad_out_q   <= ad_out_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      busy_q     <= (state_d != IDLE);
    end
  end

  // wr_ready is the IDLE grant itself so the byte is taken on the grant edge.
  assign bus.ftdi_rd  = rd_n_q;
  assign bus.ftdi_wr  = wr_n_q;
  assign bus.ad_oe    = ad_oe_q;
  assign bus.ad_out   = ad_out_q;
  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.wr_ready = wr_ready_c;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_ftdi_fifo_arbiter.sv
// Directed bench for ftdi_fifo_arbiter with a small host FIFO model.
module tb_ftdi_fifo_arbiter;
  import laser_pkg::*;

  localparam int HOST_N = START_PKT_LEN + STOP_PKT_LEN;

  logic clock = 1'b0;
  logic resetN;
  always #5 clock = ~clock;

  ftdi_fifo_arbiter_if bus();

  ftdi_fifo_arbiter #(
    .RD_PULSE_CYC (3),
    .WR_PULSE_CYC (2),
    .TURN_CYC     (1)
  ) dut (
    .clock  (clock),
    .resetN (resetN),
    .bus    (bus)
  );

  logic       tb_rxf_n, tb_txe_n, tb_rd_req, tb_wr_valid;
  logic [7:0] tb_ad_in, tb_wr_data;

  logic       host_en;
  logic [7:0] host_bytes [HOST_N];
  int         host_idx;
  logic       host_last;
  logic       host_prev_rd;
  logic       host_rxf_n;
  logic [7:0] host_ad;

  assign host_rxf_n     = (host_idx >= HOST_N) || host_last;
  assign host_ad        = (host_idx < HOST_N) ? host_bytes[host_idx] : 8'h00;
  assign bus.ftdi_rxf_n = host_en ? host_rxf_n : tb_rxf_n;
  assign bus.ad_in      = host_en ? host_ad : tb_ad_in;
  assign bus.ftdi_txe_n = tb_txe_n;
  assign bus.rd_req     = tb_rd_req;
  assign bus.wr_valid   = tb_wr_valid;
  assign bus.wr_data    = tb_wr_data;

  int total  = 0;
  int passes = 0;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    total++;
    assert (obs == exp) passes++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic wait_idle(input string tag, input int max_cyc);
    int c = 0;
    while (bus.busy !== 1'b0 && c < max_cyc) begin
      @(negedge clock);
      c++;
    end
    chk1(tag, bus.busy, 1'b0);
  endtask

  // Host FIFO: advance on each rd rising edge, drop rxf_n during the last strobe.
  always @(negedge clock) begin
    if (!host_en) begin
      host_idx     = 0;
      host_last    = 1'b0;
      host_prev_rd = 1'b1;
    end else begin
      if (host_prev_rd == 1'b0 && bus.ftdi_rd == 1'b1) host_idx = host_idx + 1;
      if (bus.ftdi_rd == 1'b0 && host_idx == HOST_N - 1) host_last = 1'b1;
      host_prev_rd = bus.ftdi_rd;
    end
  end

  // Consumer log of every byte delivered to the TX path.
  logic [7:0] rx_log [$];
  always @(negedge clock) begin
    if (bus.rd_valid === 1'b1) rx_log.push_back(bus.rd_data);
  end

  // Bus invariants checked every cycle once out of the first reset.
  logic       mon_en;
  logic       mon_prev_wr = 1'b1;
  logic [7:0] mon_prev_ad = 8'h00;
  always @(negedge clock) begin
    if (mon_en) begin
      chk1("inv_oe_while_rd", bus.ad_oe & ~bus.ftdi_rd, 1'b0);
      chk1("inv_rd_and_wr", ~bus.ftdi_rd & ~bus.ftdi_wr, 1'b0);
      if (mon_prev_wr == 1'b0 && bus.ftdi_wr == 1'b0)
        chk8("inv_ad_out_stable", bus.ad_out, mon_prev_ad);
    end
    mon_prev_wr = bus.ftdi_wr;
    mon_prev_ad = bus.ad_out;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   exp_rd [8];
    int   exp_v  [8];
    int   exp_wr [8];
    int   exp_rdy[8];
    int   exp_oe [8];
    int   exp_bz [8];
    logic [7:0] grants [8];
    int   gcount;
    logic prev_rd, prev_oe;
    int   log_base;
    int   c;

    resetN      = 1'b0;
    tb_rxf_n    = 1'b1;
    tb_txe_n    = 1'b1;
    tb_rd_req   = 1'b0;
    tb_wr_valid = 1'b0;
    tb_ad_in    = 8'h00;
    tb_wr_data  = 8'h00;
    host_en     = 1'b0;
    mon_en      = 1'b0;

    // Reset values
    repeat (3) @(negedge clock);
    chk1("rst_rd", bus.ftdi_rd, 1'b1);
    chk1("rst_wr", bus.ftdi_wr, 1'b1);
    chk1("rst_oe", bus.ad_oe, 1'b0);
    chk8("rst_ad_out", bus.ad_out, 8'h00);
    chk8("rst_rd_data", bus.rd_data, 8'h00);
    chk1("rst_rd_valid", bus.rd_valid, 1'b0);
    chk1("rst_wr_ready", bus.wr_ready, 1'b0);
    chk1("rst_busy", bus.busy, 1'b0);
    resetN = 1'b1;
    mon_en = 1'b1;
    repeat (3) @(negedge clock);
    chk1("post_rst_busy", bus.busy, 1'b0);

    // Single read; rd_req and rxf_n both drop during the strobe
    exp_rd = '{1, 1, 0, 0, 0, 1, 1, 1};
    exp_v  = '{0, 0, 0, 0, 0, 1, 0, 0};
    tb_rd_req = 1'b1;
    tb_ad_in  = 8'hA5;
    tb_rxf_n  = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clock);
      chk1($sformatf("rd1_strobe[%0d]", i), bus.ftdi_rd, 1'(exp_rd[i-1]));
      chk1($sformatf("rd1_valid[%0d]", i), bus.rd_valid, 1'(exp_v[i-1]));
      if (i == 6) chk8("rd1_data", bus.rd_data, 8'hA5);
      if (i == 3) begin
        tb_rd_req = 1'b0;
        tb_rxf_n  = 1'b1;
      end
    end
    chk1("rd1_busy_after", bus.busy, 1'b0);

    // Single write; txe_n rises right after wr_ready
    exp_rdy = '{0, 1, 0, 0, 0, 0, 0, 0};
    exp_wr  = '{1, 1, 1, 0, 0, 1, 1, 1};
    exp_oe  = '{0, 0, 1, 1, 1, 1, 0, 0};
    exp_bz  = '{0, 0, 1, 1, 1, 1, 1, 0};
    tb_wr_valid = 1'b1;
    tb_wr_data  = 8'h3C;
    tb_txe_n    = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clock);
      chk1($sformatf("wr1_ready[%0d]", i), bus.wr_ready, 1'(exp_rdy[i-1]));
      chk1($sformatf("wr1_strobe[%0d]", i), bus.ftdi_wr, 1'(exp_wr[i-1]));
      chk1($sformatf("wr1_oe[%0d]", i), bus.ad_oe, 1'(exp_oe[i-1]));
      chk1($sformatf("wr1_busy[%0d]", i), bus.busy, 1'(exp_bz[i-1]));
      if (i == 4 || i == 5) chk8($sformatf("wr1_ad_out[%0d]", i), bus.ad_out, 8'h3C);
      if (i == 2) tb_txe_n = 1'b1;
      if (i == 3) tb_wr_valid = 1'b0;
    end

    // Reset asserted during WR_STROBE
    tb_wr_valid = 1'b1;
    tb_wr_data  = 8'h5A;
    tb_txe_n    = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clock);
      if (i == 2) tb_txe_n = 1'b1;
      if (i == 3) tb_wr_valid = 1'b0;
    end
    chk1("rstw_in_strobe", bus.ftdi_wr, 1'b0);
    resetN = 1'b0;
    #1;
    chk1("rstw_wr", bus.ftdi_wr, 1'b1);
    chk1("rstw_oe", bus.ad_oe, 1'b0);
    chk1("rstw_busy", bus.busy, 1'b0);
    chk8("rstw_ad_out", bus.ad_out, 8'h00);
    repeat (2) @(negedge clock);
    chk1("rstw_valid", bus.rd_valid, 1'b0);
    resetN = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clock);
      chk1($sformatf("rstw_idle_busy[%0d]", i), bus.busy, 1'b0);
      chk1($sformatf("rstw_idle_oe[%0d]", i), bus.ad_oe, 1'b0);
    end

    // Reset asserted during RD_STROBE discards the byte
    tb_rd_req = 1'b1;
    tb_rxf_n  = 1'b0;
    tb_ad_in  = 8'hEE;
    repeat (4) @(negedge clock);
    chk1("rstr_in_strobe", bus.ftdi_rd, 1'b0);
    tb_rd_req = 1'b0;
    tb_rxf_n  = 1'b1;
    resetN    = 1'b0;
    #1;
    chk1("rstr_rd", bus.ftdi_rd, 1'b1);
    repeat (2) @(negedge clock);
    resetN = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clock);
      chk1($sformatf("rstr_no_valid[%0d]", i), bus.rd_valid, 1'b0);
      chk1($sformatf("rstr_busy[%0d]", i), bus.busy, 1'b0);
    end
    chk8("rstr_rd_data", bus.rd_data, 8'h00);

    // Write blocked by txe_n while reads proceed, then issued after the read
    tb_wr_valid = 1'b1;
    tb_wr_data  = 8'hC3;
    tb_txe_n    = 1'b1;
    tb_rd_req   = 1'b1;
    tb_rxf_n    = 1'b0;
    tb_ad_in    = 8'h11;
    for (int i = 1; i <= 13; i++) begin
      @(negedge clock);
      if (i <= 6) begin
        chk1($sformatf("blk_ready[%0d]", i), bus.wr_ready, 1'b0);
        chk1($sformatf("blk_wr[%0d]", i), bus.ftdi_wr, 1'b1);
      end
      if (i == 3) chk1("blk_rd_low", bus.ftdi_rd, 1'b0);
      if (i == 4) tb_txe_n = 1'b0;
      if (i == 6) begin
        chk1("blk_rd_valid", bus.rd_valid, 1'b1);
        chk8("blk_rd_data", bus.rd_data, 8'h11);
      end
      if (i == 7) begin
        chk1("blk_grant_wr", bus.wr_ready, 1'b1);
        chk1("blk_rd_idle", bus.ftdi_rd, 1'b1);
      end
      if (i == 8) begin
        chk1("blk_setup_oe", bus.ad_oe, 1'b1);
        tb_wr_valid = 1'b0;
        tb_rd_req   = 1'b0;
        tb_rxf_n    = 1'b1;
      end
      if (i == 9) begin
        chk1("blk_wr_low", bus.ftdi_wr, 1'b0);
        chk8("blk_ad_out", bus.ad_out, 8'hC3);
      end
      if (i == 13) chk1("blk_done", bus.busy, 1'b0);
    end
    tb_txe_n = 1'b1;

    // Contention: both sides eligible, grants must alternate starting with read
    tb_rd_req   = 1'b1;
    tb_rxf_n    = 1'b0;
    tb_ad_in    = 8'h88;
    tb_wr_valid = 1'b1;
    tb_wr_data  = 8'h77;
    tb_txe_n    = 1'b0;
    gcount  = 0;
    prev_rd = 1'b1;
    prev_oe = 1'b0;
    for (int k = 0; k < 8; k++) grants[k] = 8'h2E;
    for (int i = 1; i <= 26; i++) begin
      @(negedge clock);
      if (bus.wr_ready === 1'b1 && gcount < 8) begin
        grants[gcount] = 8'h57;
        gcount++;
      end
      if (prev_rd === 1'b1 && bus.ftdi_rd === 1'b0) begin
        chk1($sformatf("cont_turn_prev_oe[%0d]", i), prev_oe, 1'b0);
        if (gcount < 8) begin
          grants[gcount] = 8'h52;
          gcount++;
        end
      end
      prev_rd = bus.ftdi_rd;
      prev_oe = bus.ad_oe;
    end
    chki("cont_grant_count_ge4", (gcount >= 4) ? 1 : 0, 1);
    chk8("cont_grant0", grants[0], 8'h52);
    chk8("cont_grant1", grants[1], 8'h57);
    chk8("cont_grant2", grants[2], 8'h52);
    chk8("cont_grant3", grants[3], 8'h57);
    tb_rd_req   = 1'b0;
    tb_wr_valid = 1'b0;
    tb_rxf_n    = 1'b1;
    tb_txe_n    = 1'b1;
    wait_idle("cont_idle", 20);

    // Host streams a START packet then a STOP packet
    host_bytes[0] = START_SEQ;
    for (int k = 1; k < START_PKT_LEN; k++) host_bytes[k] = 8'(k);
    host_bytes[START_PKT_LEN]     = STOP_SEQ;
    host_bytes[START_PKT_LEN + 1] = 8'd1;
    repeat (4) @(negedge clock);
    log_base  = rx_log.size();
    tb_rd_req = 1'b1;
    host_en   = 1'b1;
    @(negedge clock);
    c = 0;
    while (!(host_idx == HOST_N && bus.busy === 1'b0) && c < 200) begin
      @(negedge clock);
      c++;
    end
    chki("stream_host_drained", host_idx, HOST_N);
    repeat (6) @(negedge clock);
    chki("stream_count", rx_log.size() - log_base, HOST_N);
    for (int k = 0; k < HOST_N; k++) begin
      if (log_base + k < rx_log.size())
        chk8($sformatf("stream_byte[%0d]", k), rx_log[log_base + k], host_bytes[k]);
      else
        chk8($sformatf("stream_byte[%0d]_missing", k), 8'hXX, host_bytes[k]);
    end
    tb_rd_req = 1'b0;
    host_en   = 1'b0;
    repeat (3) @(negedge clock);
    chk1("stream_end_idle", bus.busy, 1'b0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
